// File: rtl/mips_run_monitor.sv
// Run-control and trace monitor for the MIPS core harness: detects program end
// (NOP run + drain, or cycle-limit timeout) and buffers non-NOP ALU results.
module mips_run_monitor #(
  parameter int DATA_W       = 32,
  parameter int NOP_LIMIT    = 4,
  parameter int DRAIN_CYCLES = 1,
  parameter int MAX_CYCLES   = 1024,
  parameter int TRACE_DEPTH  = 16,
  parameter int CNT_W        = 16
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_start,
  input  logic                               i_instr_valid,
  input  logic [31:0]                        i_instr,
  input  logic [DATA_W-1:0]                  i_alu_result,
  input  logic                               i_trace_pop,
  output logic                               o_trace_valid,
  output logic [DATA_W-1:0]                  o_trace_data,
  output logic [$clog2(TRACE_DEPTH+1)-1:0]   o_trace_count,
  output logic                               o_trace_overflow,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_timeout,
  output logic [$clog2(NOP_LIMIT+1)-1:0]     o_nop_run,
  output logic [CNT_W-1:0]                   o_cycle_count,
  output logic [CNT_W-1:0]                   o_instr_count
);

  localparam int CW = $clog2(TRACE_DEPTH+1);
  localparam int NW = $clog2(NOP_LIMIT+1);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES+1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DW-1:0]     r_drain_cnt;
  logic [DW-1:0]     w_next_drain;
  logic [NW-1:0]     r_nop_run;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_instr_count;

  logic [DATA_W-1:0] r_mem [TRACE_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_active;
  logic w_arm;
  logic w_op;
  logic w_nop;
  logic w_nop_hit;
  logic w_time_hit;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_push_ok;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_arm      = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_TIMEOUT));
  assign w_op       = i_instr_valid && (i_instr != 32'h0);
  assign w_nop      = i_instr_valid && (i_instr == 32'h0);
  assign w_nop_hit  = (r_state == S_RUN) && w_nop && (r_nop_run == NW'(NOP_LIMIT-1));
  assign w_time_hit = (r_state == S_RUN) && (r_cycle_count == CNT_W'(MAX_CYCLES-1));

  assign w_push    = w_active && w_op;
  assign w_pop     = i_trace_pop && (r_count != '0);
  assign w_full    = (r_count == CW'(TRACE_DEPTH));
  assign w_push_ok = w_push && (!w_full || w_pop);

  // Next-state logic; a NOP-limit event takes priority over the cycle budget.
  always_comb begin
    w_next_state = r_state;
    w_next_drain = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_nop_hit) begin
          if (DRAIN_CYCLES == 0) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_DRAIN;
            w_next_drain = DW'(DRAIN_CYCLES);
          end
        end else if (w_time_hit) begin
          w_next_state = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt <= DW'(1)) begin
          w_next_state = S_DONE;
          w_next_drain = '0;
        end else begin
          w_next_drain = r_drain_cnt - DW'(1);
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (i_start) w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      o_busy      <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      o_done      <= (w_next_state == S_DONE);
      o_timeout   <= (w_next_state == S_TIMEOUT);
    end
  end

  // Run counters only move while RUN/DRAIN; all saturate instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_arm) begin
      r_nop_run     <= '0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else if (w_active) begin
      if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_op) begin
        r_nop_run <= '0;
        if (r_instr_count != '1) r_instr_count <= r_instr_count + CNT_W'(1);
      end else if (w_nop && (r_nop_run != NW'(NOP_LIMIT))) begin
        r_nop_run <= r_nop_run + NW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_alu_result;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_arm) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_trace_valid    = (r_count != '0);
  assign o_trace_data     = o_trace_valid ? r_mem[r_rd_ptr] : '0;
  assign o_trace_count    = r_count;
  assign o_trace_overflow = r_overflow;
  assign o_nop_run        = r_nop_run;
  assign o_cycle_count    = r_cycle_count;
  assign o_instr_count    = r_instr_count;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor: three parameter variants share one
// stimulus bus; the selected instance is checked against directed expectations.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        instrValid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] aluResult = 32'h0;
  logic        tracePop = 1'b0;

  localparam logic [31:0] OP = 32'h2008_0001;

  always #5 clk = ~clk;

  // Instance A: defaults. B: MAX_CYCLES=64, TRACE_DEPTH=4. C: NOP_LIMIT=1, DRAIN_CYCLES=0.
  logic        aTv, aOvf, aBusy, aDone, aTo;
  logic [31:0] aTd;
  logic [4:0]  aCnt;
  logic [2:0]  aNop;
  logic [15:0] aCyc, aIns;
  logic        bTv, bOvf, bBusy, bDone, bTo;
  logic [31:0] bTd;
  logic [2:0]  bCnt;
  logic [2:0]  bNop;
  logic [15:0] bCyc, bIns;
  logic        cTv, cOvf, cBusy, cDone, cTo;
  logic [31:0] cTd;
  logic [4:0]  cCnt;
  logic [0:0]  cNop;
  logic [15:0] cCyc, cIns;

  mips_run_monitor dutA (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_instr_valid(instrValid),
    .i_instr(instr), .i_alu_result(aluResult), .i_trace_pop(tracePop),
    .o_trace_valid(aTv), .o_trace_data(aTd), .o_trace_count(aCnt),
    .o_trace_overflow(aOvf), .o_busy(aBusy), .o_done(aDone), .o_timeout(aTo),
    .o_nop_run(aNop), .o_cycle_count(aCyc), .o_instr_count(aIns));

  mips_run_monitor #(.MAX_CYCLES(64), .TRACE_DEPTH(4)) dutB (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_instr_valid(instrValid),
    .i_instr(instr), .i_alu_result(aluResult), .i_trace_pop(tracePop),
    .o_trace_valid(bTv), .o_trace_data(bTd), .o_trace_count(bCnt),
    .o_trace_overflow(bOvf), .o_busy(bBusy), .o_done(bDone), .o_timeout(bTo),
    .o_nop_run(bNop), .o_cycle_count(bCyc), .o_instr_count(bIns));

  mips_run_monitor #(.NOP_LIMIT(1), .DRAIN_CYCLES(0)) dutC (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_instr_valid(instrValid),
    .i_instr(instr), .i_alu_result(aluResult), .i_trace_pop(tracePop),
    .o_trace_valid(cTv), .o_trace_data(cTd), .o_trace_count(cCnt),
    .o_trace_overflow(cOvf), .o_busy(cBusy), .o_done(cDone), .o_timeout(cTo),
    .o_nop_run(cNop), .o_cycle_count(cCyc), .o_instr_count(cIns));

  int          sel = 0;
  logic        sTv, sOvf, sBusy, sDone, sTo;
  logic [31:0] sTd;
  int unsigned sCnt, sNop, sCyc, sIns;

  always_comb begin
    sTv = aTv; sTd = aTd; sCnt = aCnt; sOvf = aOvf; sBusy = aBusy;
    sDone = aDone; sTo = aTo; sNop = aNop; sCyc = aCyc; sIns = aIns;
    if (sel == 1) begin
      sTv = bTv; sTd = bTd; sCnt = bCnt; sOvf = bOvf; sBusy = bBusy;
      sDone = bDone; sTo = bTo; sNop = bNop; sCyc = bCyc; sIns = bIns;
    end else if (sel == 2) begin
      sTv = cTv; sTd = cTd; sCnt = cCnt; sOvf = cOvf; sBusy = cBusy;
      sDone = cDone; sTo = cTo; sNop = cNop; sCyc = cCyc; sIns = cIns;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];

  // Scoreboard monitor: every pop the DUT accepts must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && sTv && tracePop) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL trace_extra: got %0d, expected no entry", sTd);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        if (sTd !== e) begin
          bad++;
          $display("[TB] FAIL trace_data: got %0d, expected %0d", sTd, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] alu, input logic pop);
    instrValid = v;
    instr      = ins;
    aluResult  = alu;
    tracePop   = pop;
    tick();
  endtask

  task automatic checkOutput(input string name, input int unsigned act,
                             input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkState(input logic b, input logic d, input logic t);
    checkOutput("busy", sBusy, b);
    checkOutput("done", sDone, d);
    checkOutput("timeout", sTo, t);
  endtask

  task automatic checkAllZero();
    checkState(0, 0, 0);
    checkOutput("trace_valid", sTv, 0);
    checkOutput("trace_data", sTd, 0);
    checkOutput("trace_count", sCnt, 0);
    checkOutput("trace_overflow", sOvf, 0);
    checkOutput("nop_run", sNop, 0);
    checkOutput("cycle_count", sCyc, 0);
    checkOutput("instr_count", sIns, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic armRun();
    start = 1'b1;
    applyStimulus(0, 0, 0, 0);
    start = 1'b0;
  endtask

  task automatic popN(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 1);
    tracePop = 1'b0;
  endtask

  task automatic checkDrained();
    checkOutput("queue_left", expQ.size(), 0);
    checkOutput("trace_valid_end", sTv, 0);
    expQ.delete();
  endtask

  initial begin
    // Program end by NOP run, default parameters.
    sel = 0;
    doReset();
    checkAllZero();
    armRun();
    checkState(1, 0, 0);
    checkOutput("cycle_count_arm", sCyc, 0);
    applyStimulus(1, OP, 10, 0); expQ.push_back(10);
    applyStimulus(1, OP, 11, 0); expQ.push_back(11);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0);
    checkOutput("nop_run_mid", sNop, 3);
    applyStimulus(1, OP, 21, 0); expQ.push_back(21);
    checkOutput("nop_run_clear", sNop, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0);
    checkState(1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkState(1, 0, 0);
    checkOutput("nop_run_limit", sNop, 4);
    applyStimulus(0, 0, 0, 0);
    checkState(0, 1, 0);
    checkOutput("instr_count", sIns, 3);
    checkOutput("cycle_count", sCyc, 11);
    checkOutput("trace_count", sCnt, 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("cycle_frozen", sCyc, 11);
    popN(3);
    checkDrained();

    // Cycle-limit timeout with a stream of 200 non-NOPs.
    sel = 1;
    doReset();
    armRun();
    for (int i = 0; i < 200; i++) begin
      if (i < 4) expQ.push_back(32'(i + 100));
      if (i == 63) begin
        checkOutput("busy_pre_timeout", sBusy, 1);
        checkOutput("cycle_pre_timeout", sCyc, 63);
      end
      applyStimulus(1, OP, 32'(i + 100), 0);
      if (i == 63) begin
        checkState(0, 0, 1);
        checkOutput("cycle_at_timeout", sCyc, 64);
      end
    end
    checkState(0, 0, 1);
    checkOutput("cycle_frozen_to", sCyc, 64);
    checkOutput("instr_count_to", sIns, 64);
    checkOutput("overflow_to", sOvf, 1);
    checkOutput("trace_count_to", sCnt, 4);
    popN(4);
    checkDrained();
    armRun();
    checkState(1, 0, 0);
    checkOutput("cycle_rearm", sCyc, 0);

    // FIFO overflow, then push+pop while full.
    doReset();
    armRun();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) expQ.push_back(32'(i));
      applyStimulus(1, OP, 32'(i), 0);
    end
    checkOutput("trace_count_full", sCnt, 4);
    checkOutput("overflow_set", sOvf, 1);
    popN(4);
    checkDrained();
    doReset();
    armRun();
    for (int i = 1; i <= 6; i++) expQ.push_back(32'(i));
    for (int i = 1; i <= 4; i++) applyStimulus(1, OP, 32'(i), 0);
    applyStimulus(1, OP, 5, 1);
    checkOutput("count_push_pop_full", sCnt, 4);
    checkOutput("overflow_push_pop", sOvf, 0);
    applyStimulus(1, OP, 6, 1);
    popN(4);
    checkOutput("overflow_clear_end", sOvf, 0);
    checkDrained();

    // nop_run holds on invalid cycles; invalid non-NOPs are not captured.
    sel = 0;
    doReset();
    armRun();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 32'hDEAD, 99, 0);
    checkOutput("nop_hold", sNop, 1);
    checkOutput("instr_hold", sIns, 0);
    checkOutput("no_push_invalid", sCnt, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 32'hDEAD, 99, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("nop_three", sNop, 3);
    applyStimulus(1, OP, 7, 0); expQ.push_back(7);
    checkOutput("nop_reset_op", sNop, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 32'hDEAD, 99, 0);
    end
    checkOutput("nop_toggle_three", sNop, 3);
    checkState(1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("nop_toggle_limit", sNop, 4);
    checkState(1, 0, 0);
    applyStimulus(1, OP, 8, 0); expQ.push_back(8);
    checkState(0, 1, 0);
    checkOutput("drain_capture_cnt", sIns, 2);
    checkOutput("drain_capture_nop", sNop, 0);
    checkOutput("drain_trace_count", sCnt, 2);
    popN(2);
    checkDrained();

    // Reset in the middle of DRAIN.
    doReset();
    armRun();
    applyStimulus(1, OP, 31, 0);
    applyStimulus(1, OP, 32, 0);
    applyStimulus(1, OP, 33, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0);
    checkState(1, 0, 0);
    checkOutput("drain_queued", sCnt, 3);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkAllZero();
    reset = 1'b0;
    armRun();
    checkState(1, 0, 0);
    checkOutput("cycle_after_rst", sCyc, 0);
    checkOutput("instr_after_rst", sIns, 0);
    checkOutput("count_after_rst", sCnt, 0);

    // NOP_LIMIT=1, DRAIN_CYCLES=0: one valid NOP finishes immediately.
    sel = 2;
    doReset();
    armRun();
    applyStimulus(1, OP, 55, 0);
    applyStimulus(1, 0, 0, 0);
    checkState(0, 1, 0);
    checkOutput("nop_run_c", sNop, 1);
    checkOutput("trace_count_c", sCnt, 1);
    armRun();
    checkState(1, 0, 0);
    checkOutput("trace_cleared", sCnt, 0);
    checkOutput("trace_valid_cleared", sTv, 0);
    checkOutput("instr_cleared", sIns, 0);
    checkOutput("nop_cleared", sNop, 0);
    applyStimulus(1, 0, 0, 0);
    checkState(0, 1, 0);
    checkDrained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
